uart_hex_display: RTL and testbench
===================================

Name: uart_hex_display

Overview:
- Downstream consumer of the UART byte receiver.
- Takes each received byte, announced by a level toggle, and interprets it as ASCII.
- Hex digits shift into an 8-digit display buffer; control characters edit the buffer.
- Buffer contents drive a time-multiplexed, common-anode 7-segment display: active-low segments and anodes.

Parameters:
- NUM_DIGITS, 8: digits in buffer and on display; range 2..8.
- SCAN_DIV, 100000: clk cycles each digit stays lit (1 kHz per digit at 100 MHz); minimum 2.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  last received byte; stable whenever rx_toggle is stable
- rx_toggle  in  1  inverts once per received byte; same clock domain as clk
- seg  out  7  active-low segments; bit0=a … bit6=g
- dp  out  1  active-low decimal point
- an  out  NUM_DIGITS  active-low digit enables, one-hot-low
- char_accepted  out  1  one-cycle pulse per byte that changed the buffer

Behaviour:
- Reset: one clock; synchronous and active-high. On clk edge with rst=1:
  - all digits blank; scan index 0; scan counter 0; char_accepted 0.
  - seg=7'h7F, dp=1, an=all ones.
  - tog_q loads rx_toggle, so no spurious strobe after reset.
  - Reset mid-scan or mid-byte discards everything and takes effect on that edge.
- Strobe detect:
  - tog_q registers rx_toggle every cycle.
  - strobe = rx_toggle XOR tog_q (combinational).
  - The buffer updates on the edge ending the strobe cycle.
  - char_accepted is high the following cycle if the byte was acted on.
  - Back-to-back toggles on consecutive cycles are each processed.
- Buffer: NUM_DIGITS entries of {valid, nibble[3:0]}. Entry 0 is the rightmost digit.
- Byte actions:
  - '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46), 'a'-'f' (0x61-0x66): entry[i] <= entry[i-1] for i>0; entry[0] <= {1, value}. The oldest digit falls off the left.
  - 0x08 backspace: entry[i] <= entry[i+1]; top entry becomes blank. On an all-blank buffer the contents do not change, but char_accepted still pulses.
  - 0x1B ESC: all entries blank.
  - Any other byte, including CR/LF: ignored, no pulse.
- Scan:
  - 17-bit counter counts 0..SCAN_DIV-1, then wraps to 0.
  - On wrap, the scan index increments modulo NUM_DIGITS.
- Outputs (registered, one cycle after index/buffer):
  - an = ~(1 << index).
  - seg = decode(entry[index]); blank entry gives 7'h7F.
  - A strobe and a scan advance in the same cycle are both applied; the new digit shows with the new buffer one cycle later.
- Decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- dp: constant 1 (off).

Decomposition:
- Package uart_disp_pkg holds:
  - ASCII constants: BS=8'h08, ESC=8'h1B, digit/letter range bounds.
  - SEG_BLANK=7'h7F.
  - The 16 segment patterns as localparams.
- Sub-module hex7seg_decoder: combinational {valid, nibble} -> seg[6:0].
- Toggle detect, buffer and scan stay in the top module.

Test Plan:
- Reset with rx_toggle=1 held, release -> no char_accepted; an cycles one-hot-low; seg=7'h7F on every digit.
- SCAN_DIV=4; send '1','2','A' as three toggles spaced 20 cycles -> entries 0..2 = A,2,1. When an=8'hFE, seg=7'b0001000. When an=8'hFB, seg=7'b1111001. Three char_accepted pulses.
- Send 9 digits '1'..'9' -> '1' shifted out; entry7='2', entry0='9'. When an=8'h7F, seg=7'b0100100.
- Buffer "12", send 0x08 -> entry0='1', entry1 blank, pulse. Then 0x08 twice more -> all blank, two more pulses.
- Send 'z', 0x0D, 0x0A -> buffer unchanged, no char_accepted.
- Toggles on two consecutive cycles with '3' then '4', then ESC -> '3','4' both land before the clear; after ESC all blank. Assert rst during scan index 5 -> an=all ones and seg=7'h7F on the next edge.

Source files
------------

// File: rtl/uart_hex_display_pkg.sv
// Shared constants and helpers for the UART hex display: ASCII codes,
// segment patterns (active-low gfedcba) and the byte classifier.
package uart_disp_pkg;

  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_ESC = 8'h1B;
  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_9   = 8'h39;
  localparam logic [7:0] ASCII_UA  = 8'h41;
  localparam logic [7:0] ASCII_UF  = 8'h46;
  localparam logic [7:0] ASCII_LA  = 8'h61;
  localparam logic [7:0] ASCII_LF  = 8'h66;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } digit_t;

  typedef enum logic [1:0] {ACT_NONE, ACT_HEX, ACT_BS, ACT_ESC} byte_action_t;

  function automatic byte_action_t classify(input logic [7:0] b);
    if ((b >= ASCII_0 && b <= ASCII_9) || (b >= ASCII_UA && b <= ASCII_UF) ||
        (b >= ASCII_LA && b <= ASCII_LF))
      return ACT_HEX;
    else if (b == ASCII_BS)
      return ACT_BS;
    else if (b == ASCII_ESC)
      return ACT_ESC;
    else
      return ACT_NONE;
  endfunction

  // Letters of either case have low nibble 1..6, so adding 9 gives 10..15.
  function automatic logic [3:0] hex_value(input logic [7:0] b);
    if (b <= ASCII_9)
      return b[3:0];
    else
      return b[3:0] + 4'd9;
  endfunction

endpackage

// File: rtl/uart_hex_display_if.sv
// Byte stream from the UART receiver into the display, with the accept pulse back.
interface uart_hex_display_if;
  logic [7:0] rx_data;
  logic       rx_toggle;
  logic       char_accepted;

  modport master (output rx_data, output rx_toggle, input char_accepted);
  modport slave  (input rx_data, input rx_toggle, output char_accepted);
endinterface

// File: rtl/uart_hex_display_decoder.sv
// Combinational {valid, nibble} to active-low 7-segment pattern; blank when invalid.
module hex7seg_decoder
  import uart_disp_pkg::*;
(
  input  digit_t     digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (digit.valid) begin
      case (digit.nibble)
        4'h0: seg = SEG_0;
        4'h1: seg = SEG_1;
        4'h2: seg = SEG_2;
        4'h3: seg = SEG_3;
        4'h4: seg = SEG_4;
        4'h5: seg = SEG_5;
        4'h6: seg = SEG_6;
        4'h7: seg = SEG_7;
        4'h8: seg = SEG_8;
        4'h9: seg = SEG_9;
        4'hA: seg = SEG_A;
        4'hB: seg = SEG_B;
        4'hC: seg = SEG_C;
        4'hD: seg = SEG_D;
        4'hE: seg = SEG_E;
        default: seg = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/uart_hex_display.sv
// Collects ASCII hex digits from the UART byte stream into a shift buffer and
// scans them onto a multiplexed common-anode 7-segment display.
module uart_hex_display
  import uart_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_hex_display_if.slave     rx,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int CNT_W = 17;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic                         tog_q;
  logic                         strobe;
  byte_action_t                 act;
  digit_t [NUM_DIGITS-1:0]      buf_q;
  digit_t [NUM_DIGITS-1:0]      buf_d;
  logic [CNT_W-1:0]             scan_cnt;
  logic [IDX_W-1:0]             scan_idx;
  logic [6:0]                   dec_seg;

  assign strobe = rx.rx_toggle ^ tog_q;
  assign act    = strobe ? classify(rx.rx_data) : ACT_NONE;
  assign dp     = 1'b1;

  always_comb begin
    buf_d = buf_q;
    case (act)
      ACT_HEX: begin
        for (int i = NUM_DIGITS - 1; i > 0; i--) buf_d[i] = buf_q[i-1];
        buf_d[0] = '{valid: 1'b1, nibble: hex_value(rx.rx_data)};
      end
      ACT_BS: begin
        for (int i = 0; i < NUM_DIGITS - 1; i++) buf_d[i] = buf_q[i+1];
        buf_d[NUM_DIGITS-1] = '0;
      end
      ACT_ESC: buf_d = '0;
      default: ;
    endcase
  end

  // tog_q follows rx_toggle even in reset so a toggle held across reset is not a byte.
  always_ff @(posedge clk) begin
    tog_q <= rx.rx_toggle;
    if (rst) begin
      buf_q            <= '0;
      rx.char_accepted <= 1'b0;
    end else begin
      buf_q            <= buf_d;
      rx.char_accepted <= (act != ACT_NONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  hex7seg_decoder u_decoder (
    .digit (buf_q[scan_idx]),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      seg <= dec_seg;
      an  <= ~(NUM_DIGITS'(1) << scan_idx);
    end
  end

endmodule

// File: tb/tb_uart_hex_display.sv
// Directed self-checking bench for uart_hex_display with a fast scan rate.
module tb_uart_hex_display;

  localparam int ND = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg;
  logic          dp;
  logic [ND-1:0] an;

  uart_hex_display_if rx_if ();

  uart_hex_display #(.NUM_DIGITS(ND), .SCAN_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx_if.slave),
    .seg (seg),
    .dp  (dp),
    .an  (an)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;
  int pulse_count   = 0;

  logic [6:0] pat [0:15] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [6:0] disp [ND];
  logic [ND-1:0] seen;

  always @(negedge clk) if (rx_if.char_accepted === 1'b1) pulse_count++;

  // Snapshot what each anode shows over a few full scan rotations.
  task automatic capture(input int cycles);
    for (int k = 0; k < ND; k++) disp[k] = 7'bx;
    seen = '0;
    repeat (cycles) begin
      @(negedge clk);
      for (int k = 0; k < ND; k++)
        if (an === ~(ND'(1) << k)) begin
          disp[k] = seg;
          seen[k] = 1'b1;
        end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    rx_if.rx_data   = b;
    rx_if.rx_toggle = ~rx_if.rx_toggle;
    repeat (gap) @(posedge clk);
  endtask

  task automatic test_reset;
    int p0;
    rst = 1'b1;
    rx_if.rx_toggle = 1'b1;
    rx_if.rx_data   = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks_total++;
    if (an !== 8'hFF) $display("[TB] FAIL reset_an: got %h want ff", an); else checks_passed++;
    checks_total++;
    if (seg !== 7'h7F) $display("[TB] FAIL reset_seg: got %h want 7f", seg); else checks_passed++;
    checks_total++;
    if (dp !== 1'b1) $display("[TB] FAIL reset_dp: got %b want 1", dp); else checks_passed++;
    p0 = pulse_count;
    @(posedge clk); #1;
    rst = 1'b0;
    capture(40);
    checks_total++;
    if (pulse_count != p0) $display("[TB] FAIL reset_no_pulse: got %0d pulses want 0", pulse_count - p0); else checks_passed++;
    checks_total++;
    if (seen !== 8'hFF) $display("[TB] FAIL reset_scan_all: seen %b want 11111111", seen); else checks_passed++;
    for (int k = 0; k < ND; k++) begin
      checks_total++;
      if (disp[k] !== 7'h7F) $display("[TB] FAIL reset_blank[%0d]: got %b want 1111111", k, disp[k]); else checks_passed++;
    end
  endtask

  task automatic test_shift;
    int p0;
    p0 = pulse_count;
    send_byte("1", 20);
    send_byte("2", 20);
    send_byte("A", 20);
    capture(40);
    checks_total++;
    if (pulse_count - p0 != 3) $display("[TB] FAIL shift_pulses: got %0d want 3", pulse_count - p0); else checks_passed++;
    checks_total++;
    if (disp[0] !== 7'b0001000) $display("[TB] FAIL shift_d0: got %b want 0001000", disp[0]); else checks_passed++;
    checks_total++;
    if (disp[1] !== 7'b0100100) $display("[TB] FAIL shift_d1: got %b want 0100100", disp[1]); else checks_passed++;
    checks_total++;
    if (disp[2] !== 7'b1111001) $display("[TB] FAIL shift_d2: got %b want 1111001", disp[2]); else checks_passed++;
    checks_total++;
    if (disp[3] !== 7'h7F) $display("[TB] FAIL shift_d3: got %b want 1111111", disp[3]); else checks_passed++;
  endtask

  task automatic test_overflow;
    int p0;
    p0 = pulse_count;
    send_byte(8'h1B, 5);
    for (int i = 1; i <= 9; i++) send_byte(8'h30 + 8'(i), 3);
    repeat (5) @(posedge clk);
    capture(40);
    checks_total++;
    if (pulse_count - p0 != 10) $display("[TB] FAIL overflow_pulses: got %0d want 10", pulse_count - p0); else checks_passed++;
    for (int k = 0; k < ND; k++) begin
      checks_total++;
      if (disp[k] !== pat[9-k]) $display("[TB] FAIL overflow_d%0d: got %b want %b", k, disp[k], pat[9-k]); else checks_passed++;
    end
  endtask

  task automatic test_backspace;
    int p0;
    send_byte(8'h1B, 5);
    send_byte("1", 5);
    send_byte("2", 5);
    p0 = pulse_count;
    send_byte(8'h08, 5);
    capture(40);
    checks_total++;
    if (pulse_count - p0 != 1) $display("[TB] FAIL bs_pulse1: got %0d want 1", pulse_count - p0); else checks_passed++;
    checks_total++;
    if (disp[0] !== 7'b1111001) $display("[TB] FAIL bs_d0: got %b want 1111001", disp[0]); else checks_passed++;
    checks_total++;
    if (disp[1] !== 7'h7F) $display("[TB] FAIL bs_d1: got %b want 1111111", disp[1]); else checks_passed++;
    p0 = pulse_count;
    send_byte(8'h08, 5);
    send_byte(8'h08, 5);
    capture(40);
    checks_total++;
    if (pulse_count - p0 != 2) $display("[TB] FAIL bs_pulse2: got %0d want 2", pulse_count - p0); else checks_passed++;
    for (int k = 0; k < ND; k++) begin
      checks_total++;
      if (disp[k] !== 7'h7F) $display("[TB] FAIL bs_blank[%0d]: got %b want 1111111", k, disp[k]); else checks_passed++;
    end
  endtask

  task automatic test_ignored;
    int p0;
    send_byte("5", 5);
    p0 = pulse_count;
    send_byte("z", 5);
    send_byte(8'h0D, 5);
    send_byte(8'h0A, 5);
    capture(40);
    checks_total++;
    if (pulse_count != p0) $display("[TB] FAIL ignored_pulses: got %0d want 0", pulse_count - p0); else checks_passed++;
    checks_total++;
    if (disp[0] !== 7'b0010010) $display("[TB] FAIL ignored_d0: got %b want 0010010", disp[0]); else checks_passed++;
    checks_total++;
    if (disp[1] !== 7'h7F) $display("[TB] FAIL ignored_d1: got %b want 1111111", disp[1]); else checks_passed++;
  endtask

  task automatic test_back_to_back;
    int p0;
    send_byte(8'h1B, 5);
    p0 = pulse_count;
    send_byte("3", 0);
    send_byte("4", 10);
    capture(40);
    checks_total++;
    if (pulse_count - p0 != 2) $display("[TB] FAIL b2b_pulses: got %0d want 2", pulse_count - p0); else checks_passed++;
    checks_total++;
    if (disp[0] !== 7'b0011001) $display("[TB] FAIL b2b_d0: got %b want 0011001", disp[0]); else checks_passed++;
    checks_total++;
    if (disp[1] !== 7'b0110000) $display("[TB] FAIL b2b_d1: got %b want 0110000", disp[1]); else checks_passed++;
    send_byte(8'h1B, 5);
    capture(40);
    for (int k = 0; k < ND; k++) begin
      checks_total++;
      if (disp[k] !== 7'h7F) $display("[TB] FAIL esc_blank[%0d]: got %b want 1111111", k, disp[k]); else checks_passed++;
    end
  endtask

  task automatic test_reset_mid_scan;
    logic found;
    send_byte("7", 5);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (an === 8'hDF) found = 1'b1;
    end
    checks_total++;
    if (!found) $display("[TB] FAIL midscan_wait: an never reached df, last %h", an); else checks_passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    checks_total++;
    if (an !== 8'hFF) $display("[TB] FAIL midscan_an: got %h want ff", an); else checks_passed++;
    checks_total++;
    if (seg !== 7'h7F) $display("[TB] FAIL midscan_seg: got %b want 1111111", seg); else checks_passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks_total++;
    if (an !== 8'hFE) $display("[TB] FAIL post_reset_an: got %h want fe", an); else checks_passed++;
    checks_total++;
    if (seg !== 7'h7F) $display("[TB] FAIL post_reset_seg: got %b want 1111111", seg); else checks_passed++;
  endtask

  initial begin
    rst = 1'b1;
    rx_if.rx_toggle = 1'b1;
    rx_if.rx_data   = 8'h00;
    test_reset();
    test_shift();
    test_overflow();
    test_backspace();
    test_ignored();
    test_back_to_back();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
